request_pool: RTL and testbench
===============================

REQUEST_POOL -- requirements
Module: request_pool

Interface
REQ-001 Parameter READ_ENTRIES, default 16, depth of the read bank (power of two, 2..64).
REQ-002 Parameter WRITE_ENTRIES, default 16, depth of the write bank (power of two, 2..64).
REQ-003 Parameter NUM_SCHED, default 2, number of scheduler load channels (1..4).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset is synchronous and active-low.
REQ-006 in_valid  in  1  mapper offers in_request.
REQ-007 in_request  in  request  type, address, data from the mapper.
REQ-008 in_ready  out  1  the bank selected by in_request.req_type has a free slot.
REQ-009 in_index  out  IDX_W  allocated slot; valid while in_valid && in_ready.
REQ-010 sched_valid  in  NUM_SCHED  per-channel load request.
REQ-011 sched_type  in  NUM_SCHED x r_type  bank selected per channel.
REQ-012 sched_index  in  NUM_SCHED x IDX_W  slot to load per channel.
REQ-013 sched_grant  out  NUM_SCHED  one-hot, combinational; the channel served this cycle.
REQ-014 out_request  out  request  loaded entry, registered.
REQ-015 sending  out  1  out_request valid; asserted for one cycle per load.
REQ-016 out_channel  out  CH_W  channel that owns out_request.
REQ-017 load_error  out  1  registered, one-cycle pulse: granted load targeted an empty slot.
REQ-018 read_count / write_count  out  IDX_W+1 each  occupied slots per bank.
REQ-019 read_full / write_full  out  1 each  count equals bank depth.

Function
REQ-020 Store: on in_valid && in_ready, in_request is written into the lowest-numbered free slot of its bank; that slot becomes occupied at the next edge.
REQ-021 in_ready and in_index are derived from registered occupancy only; a slot freed in cycle N is allocatable from cycle N+1.
REQ-022 Arbitration: round-robin over channels with sched_valid high; the pointer advances to the channel after the one granted; the pointer holds when no channel is valid.
REQ-023 Load: exactly one channel is granted per cycle; in the next cycle out_request holds the granted entry, sending=1, and out_channel=channel; the slot is freed at that edge.
REQ-024 A granted load of an unoccupied slot drives load_error=1, sending=0, and leaves occupancy unchanged.
REQ-025 A store and a load in the same cycle both complete, and each count changes by the net amount (+1, -1, or 0).
REQ-026 A load of the slot being allocated in that same cycle is an empty-slot load (REQ-024).
REQ-027 out_request holds its last value when sending=0.
REQ-028 sched_index bits above the log2 of the bank depth are ignored; counts never wrap.

Reset
REQ-029 Reset empties both banks, clears all occupancy, and sets sending=0, load_error=0, out_channel=0, both counts to 0, both full flags to 0, and the round-robin pointer to 0.
REQ-030 Reset asserted mid-operation discards all stored entries and any load in flight; no sending pulse follows.
REQ-031 Entry storage needs no reset; out_request resets to all-zero.

Structure
REQ-032 request, r_type (read/write), the address and data widths, and the maximum-index constant live in types_def; IDX_W = $clog2(max(READ_ENTRIES, WRITE_ENTRIES)) and CH_W = max(1, $clog2(NUM_SCHED)) are local.
REQ-033 One sub-module, rr_arbiter (parametrised on NUM_SCHED), provides grant and pointer.
REQ-034 Each bank is an instance of identical slot-array logic generated per bank depth.

Verification
REQ-035 Store read addr 0, then read addr 1 -> in_index 0 then 1; read_count=2.
REQ-036 Fill 16 writes -> write_full=1 and in_ready=0 for writes only; after one load, in_ready=1 the next cycle, and in_index equals the freed slot.
REQ-037 Channels 0 and 1 both load continuously for 4 cycles -> grants 0,1,0,1; out_channel matches one cycle later.
REQ-038 Store write index 3 (data 11) while loading write index 1 (data 10) -> sending=1 with data 10, and write_count unchanged.
REQ-039 Load an empty read slot 5 -> load_error pulse, sending=0, and counts unchanged.
REQ-040 Assert rst low with a load granted -> the next cycle has sending=0, both counts 0, and the pointer at 0.

Source files
------------

// File: rtl/types_def.sv
// Shared request types and widths for the request pool.
package types_def;

   localparam int ADDR_W    = 16;
   localparam int DATA_W    = 32;
   localparam int MAX_INDEX = 64;

   typedef enum logic {
      R_READ  = 1'b0,
      R_WRITE = 1'b1
   } r_type;

   typedef struct packed {
      r_type             req_type;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } request;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter over the scheduler load channels.
module rr_arbiter #(
   parameter int NUM_SCHED = 2,
   localparam int CH_W = (NUM_SCHED > 1) ? $clog2(NUM_SCHED) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_SCHED-1:0] req,
   output logic [NUM_SCHED-1:0] grant,
   output logic [CH_W-1:0]      grant_idx,
   output logic                 any_grant
);

   logic [CH_W-1:0] ptr_q, ptr_d;
   int              c;

   // Search starts at the pointer and wraps, so the last winner goes last.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      c         = 0;
      for (int i = 0; i < NUM_SCHED; i++) begin
         c = (int'(ptr_q) + i) % NUM_SCHED;
         if (!any_grant && req[c]) begin
            any_grant = 1'b1;
            grant[c]  = 1'b1;
            grant_idx = CH_W'(c);
         end
      end
      ptr_d = ptr_q;
      if (any_grant) begin
         if (int'(grant_idx) == NUM_SCHED - 1) ptr_d = '0;
         else ptr_d = CH_W'(int'(grant_idx) + 1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) ptr_q <= '0;
      else ptr_q <= ptr_d;
   end

endmodule

// File: rtl/request_pool.sv
// Two-bank request store with lowest-free allocation and
// round-robin scheduled loads.
module request_pool
   import types_def::*;
#(
   parameter int READ_ENTRIES  = 16,
   parameter int WRITE_ENTRIES = 16,
   parameter int NUM_SCHED     = 2,
   localparam int IDX_W = $clog2(max2(READ_ENTRIES, WRITE_ENTRIES)),
   localparam int CH_W  = (NUM_SCHED > 1) ? $clog2(NUM_SCHED) : 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   input  request                          in_request,
   output logic                            in_ready,
   output logic [IDX_W-1:0]                in_index,
   input  logic [NUM_SCHED-1:0]            sched_valid,
   input  r_type [NUM_SCHED-1:0]           sched_type,
   input  logic [NUM_SCHED-1:0][IDX_W-1:0] sched_index,
   output logic [NUM_SCHED-1:0]            sched_grant,
   output request                          out_request,
   output logic                            sending,
   output logic [CH_W-1:0]                 out_channel,
   output logic                            load_error,
   output logic [IDX_W:0]                  read_count,
   output logic [IDX_W:0]                  write_count,
   output logic                            read_full,
   output logic                            write_full
);

   localparam logic [IDX_W:0] ONE = (IDX_W+1)'(1);

   logic [CH_W-1:0]  grant_idx;
   logic             ld_valid;
   r_type            ld_type;
   logic [IDX_W-1:0] ld_idx;

   logic [1:0]       bank_rdy;
   logic [1:0]       bank_hit;
   logic [IDX_W-1:0] bank_free [2];
   logic [IDX_W:0]   bank_cnt  [2];
   request           bank_entry [2];

   request          out_req_q, out_req_d;
   logic            sending_q, sending_d;
   logic            err_q, err_d;
   logic [CH_W-1:0] out_ch_q, out_ch_d;

   rr_arbiter #(.NUM_SCHED(NUM_SCHED)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (sched_valid),
      .grant     (sched_grant),
      .grant_idx (grant_idx),
      .any_grant (ld_valid)
   );

   assign ld_type = sched_type[grant_idx];
   assign ld_idx  = sched_index[grant_idx];

   for (genvar b = 0; b < 2; b++) begin : g_bank
      localparam int    D  = (b == 0) ? READ_ENTRIES : WRITE_ENTRIES;
      localparam int    DW = $clog2(D);
      localparam r_type BT = (b == 0) ? R_READ : R_WRITE;

      logic [D-1:0]   occ_q, occ_d;
      logic [IDX_W:0] cnt_q, cnt_d;
      request         mem_q [D];
      logic [DW-1:0]  free_idx;
      logic [DW-1:0]  slot;
      logic           store;
      logic           hit;

      // A slot being allocated this cycle is still free in occ_q,
      // so a same-cycle load of it naturally reports an empty slot.
      always_comb begin
         free_idx = '0;
         for (int i = D - 1; i >= 0; i--) begin
            if (!occ_q[i]) free_idx = DW'(i);
         end
         slot  = ld_idx[DW-1:0];
         store = in_valid && (in_request.req_type == BT) && !(&occ_q);
         hit   = ld_valid && (ld_type == BT) && occ_q[slot];
         occ_d = occ_q;
         if (store) occ_d[free_idx] = 1'b1;
         if (hit) occ_d[slot] = 1'b0;
         cnt_d = cnt_q;
         if (store && !hit) cnt_d = cnt_q + ONE;
         else if (!store && hit) cnt_d = cnt_q - ONE;
      end

      always_ff @(posedge clk) begin
         if (!rst) begin
            occ_q <= '0;
            cnt_q <= '0;
         end else begin
            occ_q <= occ_d;
            cnt_q <= cnt_d;
         end
      end

      always_ff @(posedge clk) begin
         if (store) mem_q[free_idx] <= in_request;
      end

      assign bank_rdy[b]   = !(&occ_q);
      assign bank_free[b]  = IDX_W'(free_idx);
      assign bank_cnt[b]   = cnt_q;
      assign bank_hit[b]   = hit;
      assign bank_entry[b] = mem_q[slot];
   end

   assign in_ready = bank_rdy[in_request.req_type];
   assign in_index = bank_free[in_request.req_type];

   always_comb begin
      out_req_d = out_req_q;
      out_ch_d  = out_ch_q;
      sending_d = 1'b0;
      err_d     = 1'b0;
      if (ld_valid) begin
         if (bank_hit[ld_type]) begin
            sending_d = 1'b1;
            out_req_d = bank_entry[ld_type];
            out_ch_d  = grant_idx;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         out_req_q <= '0;
         out_ch_q  <= '0;
         sending_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         out_req_q <= out_req_d;
         out_ch_q  <= out_ch_d;
         sending_q <= sending_d;
         err_q     <= err_d;
      end
   end

   assign out_request = out_req_q;
   assign out_channel = out_ch_q;
   assign sending     = sending_q;
   assign load_error  = err_q;
   assign read_count  = bank_cnt[0];
   assign write_count = bank_cnt[1];
   assign read_full   = bank_cnt[0] == (IDX_W+1)'(READ_ENTRIES);
   assign write_full  = bank_cnt[1] == (IDX_W+1)'(WRITE_ENTRIES);

endmodule

// File: tb/tb_request_pool.sv
// Directed scoreboard bench for request_pool.
module tb_request_pool;
   import types_def::*;

   localparam int RE = 16;
   localparam int WE = 16;
   localparam int NS = 2;
   localparam int IW = 4;
   localparam int CW = 1;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   in_valid;
   request                 in_request;
   logic                   in_ready;
   logic [IW-1:0]          in_index;
   logic [NS-1:0]          sched_valid;
   r_type [NS-1:0]         sched_type;
   logic [NS-1:0][IW-1:0]  sched_index;
   logic [NS-1:0]          sched_grant;
   request                 out_request;
   logic                   sending;
   logic [CW-1:0]          out_channel;
   logic                   load_error;
   logic [IW:0]            read_count;
   logic [IW:0]            write_count;
   logic                   read_full;
   logic                   write_full;

   always #5 clk = ~clk;

   request_pool #(
      .READ_ENTRIES  (RE),
      .WRITE_ENTRIES (WE),
      .NUM_SCHED     (NS)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_request  (in_request),
      .in_ready    (in_ready),
      .in_index    (in_index),
      .sched_valid (sched_valid),
      .sched_type  (sched_type),
      .sched_index (sched_index),
      .sched_grant (sched_grant),
      .out_request (out_request),
      .sending     (sending),
      .out_channel (out_channel),
      .load_error  (load_error),
      .read_count  (read_count),
      .write_count (write_count),
      .read_full   (read_full),
      .write_full  (write_full)
   );

   typedef struct {
      bit                err;
      int                ch;
      logic [DATA_W-1:0] data;
      logic [ADDR_W-1:0] addr;
   } exp_t;

   exp_t sbq[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic exp_t mk(input bit err, input int ch,
                               input logic [31:0] d);
      exp_t e;
      e.err  = err;
      e.ch   = ch;
      e.data = d;
      e.addr = ~d[15:0];
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (sending === 1'b1 || load_error === 1'b1) begin
         if (sbq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_output: sending=%0b load_error=%0b expected none",
                     sending, load_error);
         end else begin
            e = sbq.pop_front();
            chk("mon_load_error", 64'(load_error), 64'(e.err));
            chk("mon_sending", 64'(sending), 64'(!e.err));
            if (!e.err) begin
               chk("mon_channel", 64'(out_channel), 64'(e.ch));
               chk("mon_data", 64'(out_request.data), 64'(e.data));
               chk("mon_addr", 64'(out_request.addr), 64'(e.addr));
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic put(input r_type t, input logic [31:0] d, input int idx);
      in_valid = 1'b1;
      in_request = '{req_type: t, addr: ~d[15:0], data: d};
      #1;
      chk("put_in_ready", 64'(in_ready), 64'd1);
      chk("put_in_index", 64'(in_index), 64'(idx));
      tick();
      in_valid = 1'b0;
   endtask

   task automatic load(input int ch, input r_type t, input int idx,
                       input bit err, input logic [31:0] d,
                       input logic [1:0] g);
      sched_valid = '0;
      sched_valid[ch] = 1'b1;
      sched_type[ch] = t;
      sched_index[ch] = IW'(idx);
      #1;
      chk("load_grant", 64'(sched_grant), 64'(g));
      sbq.push_back(mk(err, ch, d));
      tick();
      sched_valid = '0;
   endtask

   initial begin
      rst         = 1'b0;
      in_valid    = 1'b0;
      in_request  = '{req_type: R_READ, addr: '0, data: '0};
      sched_valid = '0;
      sched_type  = {R_READ, R_READ};
      sched_index = '0;
      repeat (3) tick();

      chk("rst_sending", 64'(sending), 64'd0);
      chk("rst_load_error", 64'(load_error), 64'd0);
      chk("rst_out_channel", 64'(out_channel), 64'd0);
      chk("rst_read_count", 64'(read_count), 64'd0);
      chk("rst_write_count", 64'(write_count), 64'd0);
      chk("rst_full", 64'({read_full, write_full}), 64'd0);
      chk("rst_out_request", 64'(out_request), 64'd0);
      rst = 1'b1;
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      put(R_READ, 32'h100, 0);
      put(R_READ, 32'h101, 1);
      chk("read_count_2", 64'(read_count), 64'd2);
      chk("write_count_0", 64'(write_count), 64'd0);

      for (int i = 0; i < WE; i++) put(R_WRITE, 32'h200 + i, i);
      chk("write_full", 64'(write_full), 64'd1);
      chk("write_count_16", 64'(write_count), 64'd16);
      in_request.req_type = R_WRITE;
      #1;
      chk("full_write_not_ready", 64'(in_ready), 64'd0);
      in_request.req_type = R_READ;
      #1;
      chk("full_read_still_ready", 64'(in_ready), 64'd1);
      chk("read_full_0", 64'(read_full), 64'd0);

      load(0, R_WRITE, 7, 1'b0, 32'h207, 2'b01);
      in_request.req_type = R_WRITE;
      #1;
      chk("freed_in_ready", 64'(in_ready), 64'd1);
      chk("freed_in_index", 64'(in_index), 64'd7);
      chk("write_count_15", 64'(write_count), 64'd15);
      chk("write_full_0", 64'(write_full), 64'd0);

      load(1, R_WRITE, 6, 1'b0, 32'h206, 2'b10);

      sched_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         sched_type[0]  = R_WRITE;
         sched_index[0] = (k == 0) ? IW'(0) : IW'(1);
         sched_type[1]  = R_READ;
         sched_index[1] = (k < 2) ? IW'(0) : IW'(1);
         #1;
         chk("rr_grant", 64'(sched_grant),
             (k % 2 == 0) ? 64'd1 : 64'd2);
         if (k % 2 == 0)
            sbq.push_back(mk(1'b0, 0, 32'h200 + 32'(sched_index[0])));
         else
            sbq.push_back(mk(1'b0, 1, 32'h100 + 32'(sched_index[1])));
         tick();
      end
      sched_valid = '0;
      chk("rr_read_count", 64'(read_count), 64'd0);
      chk("rr_write_count", 64'(write_count), 64'd12);

      rst = 1'b0;
      sched_valid = 2'b01;
      sched_type[0] = R_WRITE;
      sched_index[0] = IW'(2);
      tick();
      sched_valid = '0;
      chk("mid_rst_sending", 64'(sending), 64'd0);
      chk("mid_rst_load_error", 64'(load_error), 64'd0);
      chk("mid_rst_counts", 64'({read_count, write_count}), 64'd0);
      chk("mid_rst_out_channel", 64'(out_channel), 64'd0);
      tick();
      rst = 1'b1;
      sched_valid = 2'b11;
      sched_type = {R_READ, R_READ};
      sched_index = {IW'(5), IW'(5)};
      #1;
      chk("rst_ptr_grant", 64'(sched_grant), 64'd1);
      sbq.push_back(mk(1'b1, 0, 32'h0));
      tick();
      sched_valid = '0;

      put(R_WRITE, 32'd9, 0);
      put(R_WRITE, 32'd10, 1);
      put(R_WRITE, 32'd12, 2);
      in_valid = 1'b1;
      in_request = '{req_type: R_WRITE, addr: ~16'd11, data: 32'd11};
      sched_valid = 2'b10;
      sched_type[1] = R_WRITE;
      sched_index[1] = IW'(1);
      #1;
      chk("st_ld_in_index", 64'(in_index), 64'd3);
      chk("st_ld_grant", 64'(sched_grant), 64'd2);
      sbq.push_back(mk(1'b0, 1, 32'd10));
      tick();
      in_valid = 1'b0;
      sched_valid = '0;
      chk("st_ld_write_count", 64'(write_count), 64'd3);

      put(R_READ, 32'h55, 0);
      load(0, R_READ, 5, 1'b1, 32'h0, 2'b01);
      chk("empty_sending", 64'(sending), 64'd0);
      chk("empty_load_error", 64'(load_error), 64'd1);
      chk("empty_read_count", 64'(read_count), 64'd1);
      chk("empty_write_count", 64'(write_count), 64'd3);

      in_valid = 1'b1;
      in_request = '{req_type: R_WRITE, addr: ~16'h77, data: 32'h77};
      sched_valid = 2'b01;
      sched_type[0] = R_WRITE;
      sched_index[0] = IW'(1);
      #1;
      chk("alloc_ld_in_index", 64'(in_index), 64'd1);
      chk("alloc_ld_grant", 64'(sched_grant), 64'd1);
      sbq.push_back(mk(1'b1, 0, 32'h0));
      tick();
      in_valid = 1'b0;
      sched_valid = '0;
      chk("alloc_ld_write_count", 64'(write_count), 64'd4);

      load(1, R_WRITE, 1, 1'b0, 32'h77, 2'b10);
      load(0, R_WRITE, 3, 1'b0, 32'd11, 2'b01);
      chk("final_write_count", 64'(write_count), 64'd2);

      repeat (3) tick();
      chk("scoreboard_drained", 64'(sbq.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
